// File: rtl/inst_mem_loader_pkg.sv
// Shared constants for the instruction memory loader: FSM encodings, word geometry, halt marker.
package inst_mem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned CNT_W          = 2;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/byte_assembler.sv
// Collects big-endian bytes into a word; word_out/word_valid present the word combinationally
// in the cycle the final byte arrives so the parent can register the write on that same edge.
module byte_assembler
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  byte_valid,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  word_valid
);

  localparam int unsigned SHIFT_W = DATA_WIDTH - BYTE_W;

  logic [SHIFT_W-1:0] shift;
  logic [CNT_W-1:0]   byte_cnt;
  logic               last_byte;

  assign last_byte  = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign word_valid = byte_valid && !clear && last_byte;
  assign word_out   = {shift, byte_in};

  // clear has priority over a byte arriving in the same cycle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift    <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      if (last_byte) begin
        shift    <= '0;
        byte_cnt <= '0;
      end else begin
        shift    <= {shift[SHIFT_W-BYTE_W-1:0], byte_in};
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Fills instruction memory from the UART byte stream and holds the CPU until the program is loaded.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of every written word.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DATA_WIDTH'(HALT_INSTR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_done,
  output logic                  wr_en,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  overflow
`ifdef LOADER_CHECKSUM_EN
  ,output logic [DATA_WIDTH-1:0] checksum
`endif
);

  logic [1:0]            state, state_nxt;
  logic [ADDR_BITS-1:0]  word_ptr, word_ptr_nxt;
  logic                  overflow_nxt;
  logic                  wr_en_nxt;
  logic [ADDR_BITS-1:0]  wr_addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_valid;
  logic                  ptr_last;

  // bytes only count while loading; load_start drops any partial word
  byte_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_in    (rx_data),
    .byte_valid (rx_done && (state == ST_LOAD)),
    .word_out   (word),
    .word_valid (word_valid)
  );

  assign ptr_last = (word_ptr == ADDR_BITS'(MEM_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_ptr  <= '0;
      overflow  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      state     <= state_nxt;
      word_ptr  <= word_ptr_nxt;
      overflow  <= overflow_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      load_done <= (state_nxt == ST_DONE);
      cpu_hold  <= !((state_nxt == ST_DONE) && !overflow_nxt);
    end
  end

  always_comb begin
    state_nxt    = state;
    word_ptr_nxt = word_ptr;
    overflow_nxt = overflow;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_nxt    = ST_LOAD;
          word_ptr_nxt = '0;
          overflow_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          word_ptr_nxt = '0;
          overflow_nxt = 1'b0;
        end else if (word_valid) begin
          wr_en_nxt    = 1'b1;
          wr_addr_nxt  = word_ptr;
          wr_data_nxt  = word;
          word_ptr_nxt = word_ptr + ADDR_BITS'(1);
          // halt wins over full: a halt in the last slot is a clean finish
          if (word == HALT_INSTR) begin
            state_nxt = ST_DONE;
          end else if (ptr_last) begin
            state_nxt    = ST_DONE;
            overflow_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      checksum <= '0;
    end else if (wr_en_nxt) begin
      checksum <= checksum ^ wr_data_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader (MEM_DEPTH=4); covers LOADER_CHECKSUM_EN when defined.
module tb_inst_mem_loader;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, load_start, rx_done;
  logic [7:0]  rx_data;
  logic        wr_en, cpu_hold, load_done, overflow;
  logic [31:0] wr_addr, wr_data;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  inst_mem_loader #(
    .ADDR_BITS  (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (DEPTH),
    .HALT_INSTR (HALT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .overflow   (overflow)
`ifdef LOADER_CHECKSUM_EN
    ,.checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // every write strobe the DUT issues, in order
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tx[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic pulse_start(input logic collide);
    load_start = 1'b1;
    rx_done    = collide;
    rx_data    = 8'h99;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    rx_done    = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    tx.push_back(w[31:24]);
    tx.push_back(w[23:16]);
    tx.push_back(w[15:8]);
    tx.push_back(w[7:0]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " wr_en"},     64'(wr_en),     64'(0));
    chk({tag, " wr_addr"},   64'(wr_addr),   64'(0));
    chk({tag, " wr_data"},   64'(wr_data),   64'(0));
    chk({tag, " cpu_hold"},  64'(cpu_hold),  64'(1));
    chk({tag, " load_done"}, 64'(load_done), 64'(0));
    chk({tag, " overflow"},  64'(overflow),  64'(0));
`ifdef LOADER_CHECKSUM_EN
    chk({tag, " checksum"},  64'(checksum),  64'(0));
`endif
  endtask

  // Start a load, stream tx with random gaps, then compare against a word-level model:
  // group bytes big-endian, write consecutive addresses, stop after HALT or after DEPTH words.
  task automatic run_load(input string tag, input int max_gap, input logic collide);
    int          base;
    int          nw;
    logic [31:0] w;
    logic [31:0] exp_data[$];
    logic        halt_seen, ovf, done;
    logic [31:0] csum;
    base = log_addr.size();
    pulse_start(collide);
    foreach (tx[i]) begin
      send_byte(tx[i]);
      idle(int'($urandom_range(0, max_gap)));
    end
    idle(3);

    halt_seen = 1'b0;
    ovf       = 1'b0;
    csum      = '0;
    nw        = tx.size() / 4;
    for (int i = 0; i < nw; i++) begin
      if (halt_seen || ovf) break;
      w = {tx[4*i], tx[4*i+1], tx[4*i+2], tx[4*i+3]};
      exp_data.push_back(w);
      csum = csum ^ w;
      if (w == HALT) halt_seen = 1'b1;
      else if (exp_data.size() == DEPTH) ovf = 1'b1;
    end
    done = halt_seen || ovf;

    chk({tag, " write count"}, 64'(log_addr.size() - base), 64'(exp_data.size()));
    foreach (exp_data[i]) begin
      if (base + i < log_addr.size()) begin
        chk($sformatf("%s addr[%0d]", tag, i), 64'(log_addr[base+i]), 64'(i));
        chk($sformatf("%s data[%0d]", tag, i), 64'(log_data[base+i]), 64'(exp_data[i]));
      end
    end
    chk({tag, " load_done"}, 64'(load_done), 64'(done));
    chk({tag, " overflow"},  64'(overflow),  64'(ovf));
    chk({tag, " cpu_hold"},  64'(cpu_hold),  64'(!(done && !ovf)));
`ifdef LOADER_CHECKSUM_EN
    if (done) chk({tag, " checksum"}, 64'(checksum), 64'(csum));
`endif
  endtask

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    rx_done    = 1'b0;
    rx_data    = 8'h00;
    idle(3);
    check_reset_vals("reset");
    reset = 1'b0;
    idle(1);

    // first word: write appears the cycle after the 4th byte, for one cycle only
    pulse_start(1'b0);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    chk("first wr_en",    64'(wr_en),    64'(1));
    chk("first wr_addr",  64'(wr_addr),  64'(0));
    chk("first wr_data",  64'(wr_data),  64'h12345678);
    chk("first cpu_hold", 64'(cpu_hold), 64'(1));
    idle(1);
    chk("first pulse end", 64'(wr_en),   64'(0));

    // two words then HALT
    tx.delete();
    push_word($urandom());
    push_word($urandom());
    push_word(HALT);
    run_load("halt", 2, 1'b0);

    // fill memory without HALT; the 5th word must be ignored
    tx.delete();
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    push_word(32'h3333_3333);
    push_word(32'h4444_4444);
    push_word(32'h5555_5555);
    run_load("full", 1, 1'b0);

    // partial word discarded by a restart
    pulse_start(1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    tx.delete();
    push_word(32'hAABB_CCDD);
    run_load("restart", 0, 1'b0);

    // byte arriving with load_start is dropped
    tx.delete();
    push_word(32'hCAFE_F00D);
    run_load("collide", 1, 1'b1);

    // reset mid-word clears partial bytes and outputs
    pulse_start(1'b0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    reset = 1'b1;
    idle(1);
    check_reset_vals("midreset");
    idle(1);
    reset = 1'b0;
    tx.delete();
    push_word(32'h0BAD_F00D);
    run_load("post reset", 1, 1'b0);

    // checksum reference words
    tx.delete();
    push_word(32'h0000_0001);
    push_word(32'h0000_0003);
    push_word(HALT);
    run_load("csum", 1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    chk("csum fixed", 64'(checksum), 64'hFFFFFFFD);
`endif

    // random programs, with or without a terminating HALT
    for (int it = 0; it < 8; it++) begin
      tx.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) push_word($urandom());
      if ($urandom_range(0, 1) == 1) push_word(HALT);
      run_load($sformatf("rand%0d", it), 2, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
